mem_bus_arbiter: RTL and testbench

Shares a single unified `mem` port between the fetch stream (`pc_addr`/`im_command`) and the data stream (`proc2Dmem_addr`/`proc2Dmem_command`), using the existing response/tag bus protocol. The arbiter sits between `processor` and one `mem` instance and replaces the separate IM/DM memories. Returned load data is routed to the requester that issued it by tracking outstanding tags. A requester that loses arbitration sees `response == 0` and retries, exactly as it does when memory is busy.

---
 rtl/mem_bus_arbiter_pkg.sv | 33 +++
 rtl/mem_bus_arbiter_if.sv | 44 ++++
 rtl/mem_tag_table.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CMD_W     = 2;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned TAG_DEPTH = 16;

  // Bus command encodings shared with the processor and memory model.
  localparam logic [CMD_W-1:0] BUS_NONE  = 2'h0;
  localparam logic [CMD_W-1:0] BUS_LOAD  = 2'h1;
  localparam logic [CMD_W-1:0] BUS_STORE = 2'h2;

  // Which requester owns an outstanding load tag.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } owner_e;

  // Request payload driven onto the memory port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CMD_W-1:0]  cmd;
  } mem_req_t;

  // True when a requester is asking for the bus this cycle.
  function automatic logic bus_active(input logic [CMD_W-1:0] cmd);
    return cmd != BUS_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and memory.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic [ADDR_W-1:0] if_addr;
  logic [CMD_W-1:0]  if_command;
  logic [TAG_W-1:0]  if_response;
  logic [DATA_W-1:0] if_rdata;
  logic [TAG_W-1:0]  if_tag;

  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [CMD_W-1:0]  dm_command;
  logic [TAG_W-1:0]  dm_response;
  logic [DATA_W-1:0] dm_rdata;
  logic [TAG_W-1:0]  dm_tag;

  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [CMD_W-1:0]  proc2mem_command;

  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;

  logic              tag_err;

  // Arbiter side.
  modport slave (
    input  if_addr, if_command, dm_addr, dm_wdata, dm_command,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output if_response, if_rdata, if_tag, dm_response, dm_rdata, dm_tag,
           proc2mem_addr, proc2mem_data, proc2mem_command, tag_err
  );

  // Requester / memory side.
  modport master (
    output if_addr, if_command, dm_addr, dm_wdata, dm_command,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  if_response, if_rdata, if_tag, dm_response, dm_rdata, dm_tag,
           proc2mem_addr, proc2mem_data, proc2mem_command, tag_err
  );

endinterface

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table: records which requester owns each live tag.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_e           alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             hit,
  output owner_e           owner
);

  logic [TAG_DEPTH-1:0] valid_q;
  owner_e               owner_q [TAG_DEPTH];

  // Lookup of the returning tag; tag 0 means no return and never hits.
  always_comb begin
    hit   = (ret_tag != '0) && valid_q[ret_tag];
    owner = owner_q[ret_tag];
  end

  // Free on a hit, then allocate; the later write lets allocate win on a shared tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        owner_q[i] <= OWNER_IF;
      end
    end else begin
      if (hit) begin
        valid_q[ret_tag] <= 1'b0;
      end
      if (alloc_en && (alloc_tag != '0)) begin
        valid_q[alloc_tag] <= 1'b1;
        owner_q[alloc_tag] <= alloc_owner;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and data requests onto one memory port and routes tagged
// load returns back to whichever side issued them.
// Optional: MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
// (IF forced to win after STARVE_LIMIT consecutive losses to DM).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  logic     if_req;
  logic     dm_req;
  logic     force_if;
  logic     grant_if;
  logic     grant_dm;
  logic     alloc_en;
  logic     hit;
  owner_e   ret_owner;
  mem_req_t req;
  logic     tag_err_q;

  // Same-cycle grant; DM has priority unless the starvation guard forces IF.
  always_comb begin
    if_req   = bus_active(bus.if_command);
    dm_req   = bus_active(bus.dm_command);
    grant_if = if_req && (!dm_req || force_if);
    grant_dm = dm_req && !grant_if;
  end

  // Winner's request onto the memory port; idle port when nobody wins.
  always_comb begin
    req = '0;
    if (!rst) begin
      if (grant_if) begin
        req.addr = bus.if_addr;
        req.cmd  = bus.if_command;
      end else if (grant_dm) begin
        req.addr = bus.dm_addr;
        req.data = bus.dm_wdata;
        req.cmd  = bus.dm_command;
      end
    end
  end

  // Only accepted loads leave a tag outstanding; stores finish on acceptance.
  always_comb begin
    alloc_en = !rst && (req.cmd == BUS_LOAD) && (bus.mem2proc_response != '0);
  end

  mem_tag_table u_tag_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_tag   (bus.mem2proc_response),
    .alloc_owner (grant_dm ? OWNER_DM : OWNER_IF),
    .ret_tag     (bus.mem2proc_tag),
    .hit         (hit),
    .owner       (ret_owner)
  );

  // Drive memory port, route acceptance to the winner and returns to the owner.
  always_comb begin
    bus.proc2mem_addr    = req.addr;
    bus.proc2mem_data    = req.data;
    bus.proc2mem_command = req.cmd;
    bus.if_response      = '0;
    bus.dm_response      = '0;
    bus.if_rdata         = '0;
    bus.if_tag           = '0;
    bus.dm_rdata         = '0;
    bus.dm_tag           = '0;
    bus.tag_err          = tag_err_q && !rst;
    if (!rst) begin
      if (grant_if) begin
        bus.if_response = bus.mem2proc_response;
      end else if (grant_dm) begin
        bus.dm_response = bus.mem2proc_response;
      end
      if (hit) begin
        if (ret_owner == OWNER_DM) begin
          bus.dm_rdata = bus.mem2proc_data;
          bus.dm_tag   = bus.mem2proc_tag;
        end else begin
          bus.if_rdata = bus.mem2proc_data;
          bus.if_tag   = bus.mem2proc_tag;
        end
      end
    end
  end

  // Sticky flag for returns whose tag has no owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_err_q <= 1'b0;
    end else if ((bus.mem2proc_tag != '0) && !hit) begin
      tag_err_q <= 1'b1;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;

  // IF is forced through once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));
  end

  // Count IF losses; idle or granted IF clears it, a refused winner holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (bus.mem2proc_response == '0) begin
      starve_cnt <= starve_cnt;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_starve_limit;

  // Strict DM priority; the limit has no effect in this build.
  always_comb begin
    force_if            = 1'b0;
    unused_starve_limit = ^32'(STARVE_LIMIT);
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: driver pushes model expectations,
// monitor pops and compares on the falling edge.
module tb_mem_bus_arbiter;

  localparam int unsigned SL = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;

  typedef struct packed {
    logic [3:0]  if_response;
    logic [31:0] if_rdata;
    logic [3:0]  if_tag;
    logic [3:0]  dm_response;
    logic [31:0] dm_rdata;
    logic [3:0]  dm_tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  cmd;
    logic        tag_err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  obs_t  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state: tag -> owner (1 = DM), starvation count, sticky error.
  bit    owner_map [int];
  int    starve = 0;
  bit    m_err = 1'b0;

  task automatic drive(input string nm, input logic r,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] rsp, input logic [31:0] rd, input logic [3:0] rt);
    obs_t e;
    bit   if_wins;
    bit   dm_wins;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.if_command        = ic;
    bus.if_addr           = ia;
    bus.dm_command        = dc;
    bus.dm_addr           = da;
    bus.dm_wdata          = dw;
    bus.mem2proc_response = rsp;
    bus.mem2proc_data     = rd;
    bus.mem2proc_tag      = rt;
    e = '0;
    if (r) begin
      owner_map.delete();
      starve = 0;
      m_err  = 1'b0;
    end else begin
      if_wins = (ic != C_NONE) && ((dc == C_NONE) || (GUARD && (starve == int'(SL))));
      dm_wins = (dc != C_NONE) && !if_wins;
      if (if_wins) begin
        e.addr = ia;
        e.cmd  = ic;
        e.if_response = rsp;
      end else if (dm_wins) begin
        e.addr = da;
        e.data = dw;
        e.cmd  = dc;
        e.dm_response = rsp;
      end
      e.tag_err = m_err;
      if (rt != 4'd0) begin
        if (owner_map.exists(int'(rt))) begin
          if (owner_map[int'(rt)]) begin
            e.dm_tag   = rt;
            e.dm_rdata = rd;
          end else begin
            e.if_tag   = rt;
            e.if_rdata = rd;
          end
          owner_map.delete(int'(rt));
        end else begin
          m_err = 1'b1;
        end
      end
      if ((rsp != 4'd0) && ((if_wins && ic == C_LOAD) || (dm_wins && dc == C_LOAD)))
        owner_map[int'(rsp)] = dm_wins;
      if (ic == C_NONE) starve = 0;
      else if (rsp == 4'd0) starve = starve;
      else if (if_wins) starve = 0;
      else if (starve < int'(SL)) starve = starve + 1;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    drive(nm, 1'b0, C_NONE, 32'h0, C_NONE, 32'h0, 32'h0, 4'd0, 32'h0, 4'd0);
  endtask

  task automatic ret(input string nm, input logic [3:0] t, input logic [31:0] d);
    drive(nm, 1'b0, C_NONE, 32'h0, C_NONE, 32'h0, 32'h0, 4'd0, d, t);
  endtask

  task automatic do_reset();
    drive("reset", 1'b1, C_NONE, 32'h0, C_NONE, 32'h0, 32'h0, 4'd0, 32'h0, 4'd0);
    drive("reset", 1'b1, C_LOAD, 32'h40, C_STORE, 32'h44, 32'h1, 4'd2, 32'h9, 4'd3);
  endtask

  // Monitor: compare every presented output set against the queued expectation.
  initial begin
    obs_t act;
    obs_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act.if_response = bus.if_response;
        act.if_rdata    = bus.if_rdata;
        act.if_tag      = bus.if_tag;
        act.dm_response = bus.dm_response;
        act.dm_rdata    = bus.dm_rdata;
        act.dm_tag      = bus.dm_tag;
        act.addr        = bus.proc2mem_addr;
        act.data        = bus.proc2mem_data;
        act.cmd         = bus.proc2mem_command;
        act.tag_err     = bus.tag_err;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  ic;
    logic [1:0]  dc;
    logic [3:0]  rsp;
    logic [3:0]  rt;
    bus.if_command = C_NONE; bus.if_addr = '0;
    bus.dm_command = C_NONE; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem2proc_response = '0; bus.mem2proc_data = '0; bus.mem2proc_tag = '0;

    do_reset();

    // IF-only load, return, then the freed tag returning again is stray.
    drive("if_load", 1'b0, C_LOAD, 32'h100, C_NONE, 32'h0, 32'h0, 4'd3, 32'h0, 4'd0);
    idle("if_wait");
    ret("if_return", 4'd3, 32'hDEADBEEF);
    ret("if_stale_tag", 4'd3, 32'h12345678);
    idle("tag_err_set");
    do_reset();

    // Contention: DM wins, its tag returns to DM.
    drive("contend", 1'b0, C_LOAD, 32'h200, C_LOAD, 32'h400, 32'h0, 4'd6, 32'h0, 4'd0);
    ret("contend_ret", 4'd6, 32'hA5A5A5A5);

    // Continuous contention exercises the starvation guard (or strict priority).
    for (int i = 0; i < 11; i++)
      drive("starve", 1'b0, C_LOAD, 32'h300 + 32'(i), C_STORE, 32'h500 + 32'(i),
            32'(i), 4'd7 + 4'(i % 2), 32'h0, 4'd0);
    // Refused cycles hold the counter.
    for (int i = 0; i < 3; i++)
      drive("refused", 1'b0, C_LOAD, 32'h600, C_STORE, 32'h700, 32'h1, 4'd0, 32'h0, 4'd0);
    drive("after_refuse", 1'b0, C_LOAD, 32'h604, C_STORE, 32'h704, 32'h2, 4'd9, 32'h0, 4'd0);
    do_reset();

    // Out-of-order returns.
    drive("ooo_if", 1'b0, C_LOAD, 32'h1000, C_NONE, 32'h0, 32'h0, 4'd1, 32'h0, 4'd0);
    drive("ooo_dm", 1'b0, C_NONE, 32'h0, C_LOAD, 32'h2000, 32'h0, 4'd2, 32'h0, 4'd0);
    ret("ooo_ret2", 4'd2, 32'h22);
    ret("ooo_ret1", 4'd1, 32'h11);

    // Same-tag reuse: return to IF while DM reallocates the tag.
    drive("reuse_if", 1'b0, C_LOAD, 32'h3000, C_NONE, 32'h0, 32'h0, 4'd4, 32'h0, 4'd0);
    drive("reuse_both", 1'b0, C_NONE, 32'h0, C_LOAD, 32'h4000, 32'h0, 4'd4, 32'h44, 4'd4);
    ret("reuse_dm_ret", 4'd4, 32'h55);

    // Store allocates nothing; its tag returning is stray and sticks until reset.
    drive("store", 1'b0, C_NONE, 32'h0, C_STORE, 32'h80, 32'hCAFE, 4'd5, 32'h0, 4'd0);
    ret("stray", 4'd5, 32'h77);
    idle("err_hold0");
    drive("err_hold1", 1'b0, C_LOAD, 32'h8, C_NONE, 32'h0, 32'h0, 4'd10, 32'h0, 4'd0);
    do_reset();
    idle("err_cleared");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3) begin
        do_reset();
      end else begin
        ic  = ($urandom_range(99) < 60) ? C_LOAD : C_NONE;
        case ($urandom_range(2))
          0:       dc = C_NONE;
          1:       dc = C_LOAD;
          default: dc = C_STORE;
        endcase
        rsp = ($urandom_range(99) < 30) ? 4'd0 : 4'($urandom_range(15));
        rt  = ($urandom_range(99) < 50) ? 4'd0 : 4'($urandom_range(15));
        drive("random", 1'b0, ic, $urandom, dc, $urandom, $urandom, rsp, $urandom, rt);
      end
    end

    idle("drain");
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
